// File: rtl/mcu_link_pkg.sv
// Shared types and constants for the MCU byte-link command router.
package mcu_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_FWD,
        ST_STAT,
        ST_DROP
    } state_t;

    localparam logic [7:0] STATUS_ID_DEFAULT = 8'hFF;
    localparam int         MAX_TARGETS       = 8;

endpackage

// File: rtl/mcu_cmd_router.sv
// Routes MCU byte frames to one of several command targets (the first byte picks the target),
// merges the targets' interrupts and serves a pending-interrupt bitmap on a reserved id.
//
// state | meaning
// IDLE  | no frame selected, non-start bytes ignored
// CMD   | target selected, next byte goes out as its start/command byte
// FWD   | forwarding payload bytes to the selected target
// STAT  | status frame, data_out holds the interrupt snapshot
// DROP  | unknown target id, bytes swallowed until next start
module mcu_cmd_router
    import mcu_link_pkg::*;
#(
    parameter int         NUM_TARGETS = 4,
    parameter logic [7:0] STATUS_ID   = STATUS_ID_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       data_in_strobe,
    input  logic                       data_in_start,
    input  logic [7:0]                 data_in,
    output logic [7:0]                 data_out,
    output logic                       int_out_n,
    output logic [NUM_TARGETS-1:0]     tgt_strobe,
    output logic                       tgt_start,
    output logic [7:0]                 tgt_data,
    input  logic [8*NUM_TARGETS-1:0]   tgt_data_out,
    input  logic [NUM_TARGETS-1:0]     tgt_int_n
);

    state_t                       state_q, state_d;
    logic [7:0]                   sel_q, sel_d;
    logic [7:0]                   snap_q, snap_d;
    logic                         fwd, fwd_start;
    logic [NUM_TARGETS-1:0]       strobe_d;
    logic [7:0]                   dout_d;
    logic [8*MAX_TARGETS-1:0]     ret_all;

    // Return bytes padded to the full id space so the index always fits.
    always_comb begin
        ret_all = '0;
        ret_all[8*NUM_TARGETS-1:0] = tgt_data_out;
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        snap_d    = snap_q;
        fwd       = 1'b0;
        fwd_start = 1'b0;

        if (data_in_strobe) begin
            if (data_in_start) begin
                sel_d = data_in;
                if (data_in < 8'(NUM_TARGETS)) begin
                    state_d = ST_CMD;
                end else if (data_in == STATUS_ID) begin
                    state_d = ST_STAT;
                    snap_d  = '0;
                    snap_d[NUM_TARGETS-1:0] = ~tgt_int_n;
                end else begin
                    state_d = ST_DROP;
                end
            end else begin
                unique case (state_q)
                    ST_CMD: begin
                        fwd       = 1'b1;
                        fwd_start = 1'b1;
                        state_d   = ST_FWD;
                    end
                    ST_FWD:  fwd = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        strobe_d = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            strobe_d[i] = fwd && (sel_q == 8'(i));
        end
    end

    // data_out follows the next selection so a new source shows one cycle after its start byte.
    always_comb begin
        unique case (state_d)
            ST_CMD, ST_FWD: dout_d = ret_all[{sel_d[2:0], 3'b000} +: 8];
            ST_STAT:        dout_d = snap_d;
            default:        dout_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sel_q      <= 8'h00;
            snap_q     <= 8'h00;
            tgt_strobe <= '0;
            tgt_start  <= 1'b0;
            tgt_data   <= 8'h00;
            data_out   <= 8'h00;
            int_out_n  <= 1'b1;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            snap_q     <= snap_d;
            tgt_strobe <= strobe_d;
            if (fwd) begin
                tgt_start <= fwd_start;
                tgt_data  <= data_in;
            end
            data_out   <= dout_d;
            int_out_n  <= &tgt_int_n;
        end
    end

endmodule

// File: tb/tb_mcu_cmd_router.sv
// Directed bench for mcu_cmd_router: a frame-level reference model checked every cycle,
// plus literal expectations after each test-plan frame.
module tb_mcu_cmd_router;

    localparam int NT = 4;

    logic            clk;
    logic            reset;
    logic            data_in_strobe;
    logic            data_in_start;
    logic [7:0]      data_in;
    logic [7:0]      data_out;
    logic            int_out_n;
    logic [NT-1:0]   tgt_strobe;
    logic            tgt_start;
    logic [7:0]      tgt_data;
    logic [8*NT-1:0] tgt_data_out;
    logic [NT-1:0]   tgt_int_n;
    logic [7:0]      tdo [NT];

    int checks   = 0;
    int failures = 0;
    int scnt [NT];

    assign tgt_data_out = {tdo[3], tdo[2], tdo[1], tdo[0]};

    mcu_cmd_router #(.NUM_TARGETS(NT), .STATUS_ID(8'hFF)) dut (
        .clk            (clk),
        .reset          (reset),
        .data_in_strobe (data_in_strobe),
        .data_in_start  (data_in_start),
        .data_in        (data_in),
        .data_out       (data_out),
        .int_out_n      (int_out_n),
        .tgt_strobe     (tgt_strobe),
        .tgt_start      (tgt_start),
        .tgt_data       (tgt_data),
        .tgt_data_out   (tgt_data_out),
        .tgt_int_n      (tgt_int_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: which target owns the frame, whether its command byte is still due.
    int          m_tgt;        // -1 none, -2 status frame
    bit          m_first;
    logic [7:0]  m_snap;
    bit          m_valid = 0;
    logic [NT-1:0] e_strobe;
    logic        e_start;
    logic [7:0]  e_data;
    logic [7:0]  e_dout;
    logic        e_intn;

    always @(posedge clk) begin
        if (reset) begin
            m_tgt = -1; m_first = 0; m_snap = 8'h00;
            e_strobe = '0; e_start = 0; e_data = 8'h00; e_dout = 8'h00; e_intn = 1;
            m_valid = 1;
        end else begin
            e_strobe = '0;
            if (data_in_strobe) begin
                if (data_in_start) begin
                    if (int'(data_in) < NT) begin
                        m_tgt = int'(data_in); m_first = 1;
                    end else if (data_in == 8'hFF) begin
                        m_tgt = -2; m_snap = {4'b0000, ~tgt_int_n};
                    end else begin
                        m_tgt = -1; m_first = 0;
                    end
                end else if (m_tgt >= 0) begin
                    e_strobe = NT'(1 << m_tgt);
                    e_start  = m_first;
                    e_data   = data_in;
                    m_first  = 0;
                end
            end
            if (m_tgt >= 0)       e_dout = tdo[m_tgt];
            else if (m_tgt == -2) e_dout = m_snap;
            else                  e_dout = 8'h00;
            e_intn = &tgt_int_n;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("tgt_strobe", 32'(tgt_strobe), 32'(e_strobe));
            check("tgt_start",  32'(tgt_start),  32'(e_start));
            check("tgt_data",   32'(tgt_data),   32'(e_data));
            check("data_out",   32'(data_out),   32'(e_dout));
            check("int_out_n",  32'(int_out_n),  32'(e_intn));
            for (int i = 0; i < NT; i++) scnt[i] += int'(tgt_strobe[i]);
        end
    end

    task automatic send(input logic st, input logic [7:0] d);
        data_in_strobe = 1'b1; data_in_start = st; data_in = d;
        @(negedge clk);
        data_in_strobe = 1'b0; data_in_start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    int b [NT];
    task automatic snap_counts();
        for (int i = 0; i < NT; i++) b[i] = scnt[i];
    endtask

    initial begin
        for (int i = 0; i < NT; i++) begin scnt[i] = 0; tdo[i] = 8'h00; end
        reset = 1'b1; data_in_strobe = 0; data_in_start = 0; data_in = 8'h00;
        tgt_int_n = 4'b1111;
        repeat (3) @(negedge clk);
        check("reset tgt_strobe", 32'(tgt_strobe), 0);
        check("reset data_out",   32'(data_out),   0);
        check("reset int_out_n",  32'(int_out_n),  1);
        check("reset tgt_data",   32'(tgt_data),   0);
        reset = 1'b0;
        @(negedge clk);

        // frame 00,00,AA,BB to target 0
        snap_counts();
        send(1, 8'h00); send(0, 8'h00); send(0, 8'hAA); send(0, 8'hBB);
        check("f0 strobes t0", scnt[0] - b[0], 3);
        check("f0 strobes others", (scnt[1]-b[1]) + (scnt[2]-b[2]) + (scnt[3]-b[3]), 0);
        check("f0 last data", 32'(tgt_data), 32'hBB);
        check("f0 last start", 32'(tgt_start), 0);

        // frame to target 2 with return byte 5C
        tdo[2] = 8'h5C;
        snap_counts();
        send(1, 8'h02); send(0, 8'h04); send(0, 8'h52); send(0, 8'h01);
        check("f2 strobes t2", scnt[2] - b[2], 3);
        check("f2 strobes others", (scnt[0]-b[0]) + (scnt[1]-b[1]) + (scnt[3]-b[3]), 0);
        check("f2 data_out", 32'(data_out), 32'h5C);

        // status frame
        tgt_int_n = 4'b1010;
        @(negedge clk);
        check("irq merged low", 32'(int_out_n), 0);
        send(1, 8'hFF);
        check("stat bitmap", 32'(data_out), 32'h05);
        send(0, 8'h00);
        tgt_int_n = 4'b1111;
        @(negedge clk);
        check("irq released", 32'(int_out_n), 1);
        check("stat frozen", 32'(data_out), 32'h05);

        // unknown target id
        snap_counts();
        send(1, 8'h07); send(0, 8'h11); send(0, 8'h22);
        check("drop strobes", (scnt[0]-b[0]) + (scnt[1]-b[1]) + (scnt[2]-b[2]) + (scnt[3]-b[3]), 0);
        check("drop data_out", 32'(data_out), 0);

        // abort target 1 frame with a new start to target 0
        snap_counts();
        send(1, 8'h01); send(0, 8'h03); send(0, 8'h10);
        send(1, 8'h00); send(0, 8'h00);
        check("abort t1 strobes", scnt[1] - b[1], 2);
        check("abort t0 strobes", scnt[0] - b[0], 1);
        check("abort t0 start", 32'(tgt_start), 1);
        check("abort t0 data", 32'(tgt_data), 32'h00);

        // reset between bytes of a target-0 frame
        tdo[0] = 8'h3C;
        send(1, 8'h00); send(0, 8'h33);
        check("pre-reset data_out", 32'(data_out), 32'h3C);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("post-reset data_out", 32'(data_out), 0);
        check("post-reset tgt_data", 32'(tgt_data), 0);
        snap_counts();
        send(0, 8'h44);
        check("post-reset no strobe", (scnt[0]-b[0]) + (scnt[1]-b[1]) + (scnt[2]-b[2]) + (scnt[3]-b[3]), 0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mcu_cmd_router.md
# mcu_cmd_router

Routes the MCU byte link (strobe/start/data, one byte per strobe) to up to eight command targets, e.g. the system control block, HID, OSD and floppy/SD controllers. The first byte of every MCU frame selects the target. The remaining bytes are forwarded to that target as a normal frame, with the first forwarded byte acting as the start/command byte. The block also merges the targets' active-low interrupt lines into one MCU interrupt and exposes a pending-interrupt bitmap through a reserved target id.

## Interface
- NUM_TARGETS, 4: number of attached targets (1..8); target ids 0..NUM_TARGETS-1.
- STATUS_ID, 8'hFF: reserved target id that returns the interrupt bitmap.

- clk  in  1  system clock; the block uses only this clock.
- reset  in  1  synchronous, active-high.
- data_in_strobe  in  1  one-cycle pulse per MCU byte.
- data_in_start  in  1  qualifies the strobed byte as the first byte of a frame.
- data_in  in  8  MCU byte.
- data_out  out  8  byte returned to the MCU.
- int_out_n  out  1  active-low merged interrupt to the MCU.
- tgt_strobe  out  NUM_TARGETS  one-hot per-target strobe.
- tgt_start  out  1  start qualifier, shared by all targets.
- tgt_data  out  8  forwarded byte, shared by all targets.
- tgt_data_out  in  8*NUM_TARGETS  target return bytes; target i drives bits [8i+7:8i].
- tgt_int_n  in  NUM_TARGETS  active-low target interrupt outputs.

## Operation
- States: IDLE, CMD, FWD, STAT, DROP.
- IDLE: strobe without start is ignored.
- Any state, strobe with start: latch data_in as sel.
  - sel < NUM_TARGETS: go to CMD.
  - sel == STATUS_ID: go to STAT and snapshot irq_snap = ~tgt_int_n, zero-extended to 8 bits.
  - Any other value: go to DROP.
  - The selection byte is never forwarded.
  - A start arriving mid-frame aborts the current frame; the old target receives no further strobes.
- CMD, strobe without start: emit a strobe to target sel with tgt_start=1 and tgt_data=data_in, then go to FWD.
- FWD, strobe without start: emit a strobe to target sel with tgt_start=0. Stay in FWD until the next start.
- STAT, strobe: no target strobe. Stay in STAT.
- DROP, strobe: no target strobe. Stay in DROP.
- data_out per state:
  - CMD/FWD: tgt_data_out of target sel.
  - STAT: irq_snap, frozen for the whole frame.
  - IDLE/DROP: 8'h00.
- int_out_n: registered AND of all tgt_int_n bits.

## Timing
- Reset values: state IDLE, sel 0, tgt_strobe 0, tgt_start 0, tgt_data 8'h00, data_out 8'h00, int_out_n 1, irq_snap 8'h00.
- Strobe forwarding: tgt_strobe/tgt_start/tgt_data are registered and appear exactly 1 cycle after data_in_strobe.
- Strobe width: tgt_strobe is high for exactly one cycle. tgt_start and tgt_data hold until the next forwarded byte.
- data_out is registered every cycle from the current state/sel.
- Return latency: a target updating its tgt_data_out in the cycle after its strobe is visible on data_out 2 cycles after the strobe.
- MCU byte spacing is at least 4 clk. The MCU reads data_out before its next strobe.
- Selection change: data_out switches to the new source 1 cycle after the selection strobe (8'h00 before the first forwarded byte returns data).
- int_out_n: 1-cycle latency from tgt_int_n.
- Reset asserted mid-frame: all outputs take their reset values the next cycle. No partial strobe is emitted. The next frame must start with a start byte.
- Strobe with start and a forward in the same cycle cannot occur (single input strobe); start always wins.

## Structure
- Package mcu_link_pkg holds:
  - the state enum;
  - the STATUS_ID default;
  - the MAX_TARGETS=8 constant shared by all targets.
- No sub-module. The return-byte mux is an indexed part-select of tgt_data_out inside the block.

## Test plan
- Frame 00,00,AA,BB (start on 00): target 0 sees strobes with (start=1,data=00), (0,AA), (0,BB). tgt_strobe[3:1] stays 0. Each strobe lands 1 cycle after its input strobe.
- Frame 02,04,52,01 with target 2 tgt_data_out=8'h5C: only tgt_strobe[2] pulses, 3 times. data_out reads 8'h5C 2 cycles after each forwarded strobe.
- tgt_int_n=4'b1010, then frame FF,00: int_out_n=0; data_out=8'h05 throughout the frame.
  - Changing tgt_int_n to 4'b1111 mid-frame leaves data_out at 8'h05 and raises int_out_n 1 cycle later.
- Frame 07,11,22 with NUM_TARGETS=4: no tgt_strobe pulses; data_out=8'h00.
- Abort: frame 01,03,10 then a new start 00,00 before the frame ends: target 1 gets 2 strobes only; target 0 then gets (1,00).
- Reset pulsed between bytes of a target-0 frame: outputs return to reset values. A following non-start strobe produces no tgt_strobe.
